// File: rtl/ps2_key_event_fifo.sv
// PS/2 keyboard receiver, scan-code decoder and show-ahead key event FIFO.
// Optional typematic repeat suppression is enabled by defining PS2_KEY_REPEAT_FILTER_EN.
module ps2_key_event_fifo #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [15:0]                   evt_key,
  output logic                          evt_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  // ---------------------------------------------------------------
  // Two-flop synchronisers: bit 0 = ps2_clk, bit 1 = ps2_data
  // ---------------------------------------------------------------
  logic [1:0] pin_raw;
  logic [1:0] sync_meta_q;
  logic [1:0] sync_q;

  assign pin_raw = {ps2_data, ps2_clk};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk) begin
        if (reset) begin
          sync_meta_q[gi] <= 1'b1;
          sync_q[gi]      <= 1'b1;
        end else begin
          sync_meta_q[gi] <= pin_raw[gi];
          sync_q[gi]      <= sync_meta_q[gi];
        end
      end
    end
  endgenerate

  logic clk_s;
  logic data_s;
  assign clk_s  = sync_q[0];
  assign data_s = sync_q[1];

  // ---------------------------------------------------------------
  // Clock glitch filter and fall strobe
  // ---------------------------------------------------------------
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
    end else begin
      fall_q <= 1'b0;
      if (clk_s != filt_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q     <= clk_s;
          filt_cnt_q <= '0;
          fall_q     <= filt_q;
        end else begin
          filt_cnt_q <= filt_cnt_q + FW'(1);
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  // ---------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          byte_valid_q, byte_valid_d;
  logic [7:0]    byte_q, byte_d;
  logic          frame_err_q, frame_err_d;
  logic          timeout_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign timeout_hit = (state_q != S_IDLE) && (to_cnt_q == TW'(TIMEOUT_CYCLES)) && !fall_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    frame_err_d  = 1'b0;

    // Counter saturates so an idle line never wraps back into a spurious timeout
    if (fall_q) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + TW'(1);
    end

    if (timeout_hit) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b1;
    end else if (fall_q) begin
      case (state_q)
        S_IDLE: begin
          if (!data_s) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          parity_d = data_s;
          state_d  = S_STOP;
        end
        S_STOP: begin
          if (data_s && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
            byte_d       = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Byte decoder: prefix folding, ignored codes, repeat filter
  // ---------------------------------------------------------------
  logic        ext_q, ext_d;
  logic        brk_q, brk_d;
  logic        ignore_byte;
  logic        cand_evt;
  logic        repeat_drop;
  logic        push_req;
  logic [15:0] push_key;
  logic [16:0] push_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      brk_q <= brk_d;
    end
  end

  always_comb begin
    case (byte_q)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ignore_byte = 1'b1;
      default:                                   ignore_byte = 1'b0;
    endcase
  end

  assign cand_evt  = byte_valid_q && (byte_q != 8'hE0) && (byte_q != 8'hF0) && !ignore_byte;
  assign push_key  = {(ext_q ? 8'hE0 : 8'h00), byte_q};
  assign push_data = {push_key, !brk_q};
  assign push_req  = cand_evt && !repeat_drop;

  always_comb begin
    ext_d = ext_q;
    brk_d = brk_q;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (!ignore_byte) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

`ifdef PS2_KEY_REPEAT_FILTER_EN
  logic [15:0] last_make_q;
  logic        last_vld_q;

  assign repeat_drop = !brk_q && last_vld_q && (last_make_q == push_key);

  // Any break re-arms; a passed make becomes the new reference code
  always_ff @(posedge clk) begin
    if (reset) begin
      last_make_q <= '0;
      last_vld_q  <= 1'b0;
    end else if (cand_evt) begin
      if (brk_q) begin
        last_vld_q <= 1'b0;
      end else begin
        last_make_q <= push_key;
        last_vld_q  <= 1'b1;
      end
    end
  end
`else
  assign repeat_drop = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Show-ahead event FIFO
  // ---------------------------------------------------------------
  logic [16:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic [16:0]   head;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && evt_ready;
  assign push_ok   = push_req && (!fifo_full || pop);
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= push_req && fifo_full && !pop;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  assign evt_valid  = (count_q != '0);
  assign evt_key    = evt_valid ? head[16:1] : 16'h0000;
  assign evt_status = evt_valid ? head[0] : 1'b0;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule
